multi_channel_timer: RTL and testbench
======================================

// Module: multi_channel_timer
// PURPOSE
// - NUMBER independent timer channels for system sequencing. Generalises the fixed-time single-shot
//   timer: runtime-loadable per-channel periods, periodic or one-shot mode, global enable and per-channel clear.
// - Sits beside the system controller. Drives power-up sequencing, watchdog ticks and periodic sampling strobes.
// PARAMETERS
// - NUMBER    4   number of channels (>=1)
// - WIDTH     32  counter/period width per channel (2..32)
// - PRESCALE  1   global tick divider (>=1); only used when MULTI_CHANNEL_TIMER_PRESCALE_EN defined
// PORTS
// - clock     in   1             system clock, all state on rising edge
// - reset     in   1             asynchronous, active-high; clears all state immediately
// - enable    in   1             global count enable; low freezes all counters
// - load      in   NUMBER        per-channel start: latch period/mode, count restarts at 0
// - period    in   NUMBER*WIDTH  channel i period at [WIDTH*i +: WIDTH], sampled on load[i]
// - periodic  in   NUMBER        channel i mode sampled on load[i]: 1=periodic, 0=one-shot
// - clear     in   NUMBER        per-channel return to IDLE, drops sticky activate
// - trigger   out  NUMBER        one-cycle pulse on channel expiry
// - activate  out  NUMBER        trigger | done (sticky for one-shot)
// - all_done  out  1             high when every channel is in DONE
// BEHAVIOUR
// - Reset: all channels IDLE; count=0; period_q=0; mode_q=0; trigger=0; activate=0; all_done=0.
// - Per channel, 3 states:
//   - IDLE: counter held at 0.
//   - RUN: counter advances on tick.
//   - DONE: counter held; activate=1.
// - tick = enable (feature off) or enable & prescaler-wrap (feature on).
// - load[i]=1 at an edge:
//   - period==0: go IDLE. A zero period never triggers.
//   - otherwise: period_q<=period, mode_q<=periodic, count<=0, state<=RUN.
//   - Legal from any state; a load while in RUN restarts the count.
// - trigger[i] is combinational from registered state: (state==RUN) & tick & (count==period_q-1).
//   - With enable held high and no prescaler, trigger fires in the P-th cycle after the load edge.
//   - P=1 gives trigger in the first cycle after the load edge.
// - At an edge with trigger[i]=1:
//   - periodic: count<=0, stay RUN. Retriggers every P ticks.
//   - one-shot: state<=DONE.
// - Otherwise in RUN with tick: count<=count+1. No tick: count holds and trigger=0.
// - activate[i] = trigger[i] | (state==DONE). all_done = &(state==DONE).
// - Priority per channel, highest first: reset > load > clear > expiry/count.
//   - load and clear in the same cycle: load wins.
// - clear[i] while in RUN or DONE: go IDLE next edge; trigger suppressed in that cycle.
// - Counter never wraps past period_q-1. Arithmetic is unsigned, width WIDTH.
// - Channels are fully independent. Simultaneous triggers on multiple channels are legal.
// - Asynchronous reset asserted mid-count: outputs drop to 0 without a clock edge.
// CONFIGURATION
// - MULTI_CHANNEL_TIMER_PRESCALE_EN defined:
//   - Shared counter 0..PRESCALE-1 advances while enable=1; tick = enable & (pre==PRESCALE-1).
//   - Prescaler resets to 0 on reset. It is not reset by load.
//   - PRESCALE=1 is equivalent to the feature being off.
// - Not defined: no prescaler logic; tick = enable. The PRESCALE parameter is ignored.
// TESTING
// - Reset, then load[0] with period=5, periodic=0, enable=1:
//   -> trigger[0] high only in the 5th cycle after load; activate[0] stays high; all others 0.
// - Load[1] with period=3, periodic=1:
//   -> trigger[1] pulses at cycles 3, 6 and 9 after load; activate[1] never sticky.
// - Channel 2 period=4 running, enable low for 10 cycles at count=2:
//   -> no trigger while low; trigger fires 2 enabled cycles after enable returns.
// - load[3] and clear[3] in the same cycle, period=2 -> channel runs and triggers 2 cycles later.
//   - Also: load with period=0 -> channel IDLE, never triggers.
// - Load all NUMBER channels as one-shot with periods 1,2,3,4:
//   -> all_done rises the cycle after channel 3 triggers.
//   - Then clear[0] -> all_done falls next edge.
// - Assert reset asynchronously mid-count:
//   -> trigger/activate/all_done 0 immediately.
//   - With MULTI_CHANNEL_TIMER_PRESCALE_EN and PRESCALE=4, period=2: trigger at cycle 8 after load.

Source files
------------

// File: rtl/multi_channel_timer.sv
// NUMBER independent load/clear timer channels sharing one count-enable tick.
// Define MULTI_CHANNEL_TIMER_PRESCALE_EN to divide that tick by PRESCALE.

module multi_channel_timer_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic             clear,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  output logic             trigger,
  output logic             activate,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             expire;

  // In RUN, period_q is never zero, so period_q-1 cannot underflow.
  assign expire   = (state_q == RUN) & tick & (count_q == period_q - WIDTH'(1));
  assign trigger  = expire & ~clear;
  assign done     = (state_q == DONE);
  assign activate = trigger | done;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    if (load) begin
      count_d = '0;
      if (period == '0) begin
        state_d = IDLE;
      end else begin
        state_d  = RUN;
        period_d = period;
        mode_d   = periodic;
      end
    end else if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (expire) begin
      count_d = '0;
      if (!mode_q) state_d = DONE;
    end else if (state_q == RUN && tick) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end
endmodule

module multi_channel_timer #(
  parameter int NUMBER   = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUMBER-1:0]       load,
  input  logic [NUMBER*WIDTH-1:0] period,
  input  logic [NUMBER-1:0]       periodic,
  input  logic [NUMBER-1:0]       clear,
  output logic [NUMBER-1:0]       trigger,
  output logic [NUMBER-1:0]       activate,
  output logic                    all_done
);
  logic              tick;
  logic [NUMBER-1:0] done;

  if (NUMBER < 1 || WIDTH < 2 || WIDTH > 32 || PRESCALE < 1) begin : g_bad_param
    $error("multi_channel_timer: illegal parameter set");
  end

`ifdef MULTI_CHANNEL_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
  assign tick     = enable & pre_wrap;

  always_comb begin
    pre_d = pre_q;
    if (enable) pre_d = pre_wrap ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
`else
  assign tick = enable;
`endif

  for (genvar i = 0; i < NUMBER; i++) begin : g_chan
    multi_channel_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .tick     (tick),
      .load     (load[i]),
      .clear    (clear[i]),
      .periodic (periodic[i]),
      .period   (period[WIDTH*i +: WIDTH]),
      .trigger  (trigger[i]),
      .activate (activate[i]),
      .done     (done[i])
    );
  end

  assign all_done = &done;
endmodule

// File: tb/tb_multi_channel_timer.sv
// Randomized and directed bench for multi_channel_timer (default build, no prescaler),
// checked every cycle against a ticks-remaining model of each channel.

module tb_multi_channel_timer;
  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   load, periodic, clear;
  logic [N*W-1:0] period;
  logic [N-1:0]   trigger, activate;
  logic           all_done;

  int checks = 0;
  int failures = 0;

  multi_channel_timer #(.NUMBER(N), .WIDTH(W), .PRESCALE(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .period   (period),
    .periodic (periodic),
    .clear    (clear),
    .trigger  (trigger),
    .activate (activate),
    .all_done (all_done)
  );

  always #5 clock = ~clock;

  // Model: each channel is idle, running with some ticks left, or done.
  bit m_run  [N];
  bit m_done [N];
  bit m_mode [N];
  int m_rem  [N];
  int m_per  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per_of(input int i);
    return int'(period[W*i +: W]);
  endfunction

  function automatic logic [N-1:0] exp_trig();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_run[i] && enable && m_rem[i] == 1 && !clear[i];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_act();
    logic [N-1:0] r;
    r = exp_trig();
    for (int i = 0; i < N; i++) r[i] = r[i] | m_done[i];
    return r;
  endfunction

  function automatic logic exp_all();
    logic r;
    r = 1'b1;
    for (int i = 0; i < N; i++) r &= m_done[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_mode[i] = 0; m_rem[i] = 0; m_per[i] = 0;
    end
  endtask

  task automatic m_step();
    logic [N-1:0] t;
    t = exp_trig();
    for (int i = 0; i < N; i++) begin
      if (load[i]) begin
        m_done[i] = 0;
        m_run[i]  = per_of(i) != 0;
        if (per_of(i) != 0) begin
          m_per[i] = per_of(i); m_rem[i] = per_of(i); m_mode[i] = periodic[i];
        end
      end else if (clear[i]) begin
        m_run[i] = 0; m_done[i] = 0;
      end else if (t[i]) begin
        if (m_mode[i]) m_rem[i] = m_per[i];
        else begin m_run[i] = 0; m_done[i] = 1; end
      end else if (m_run[i] && enable) begin
        m_rem[i]--;
      end
    end
  endtask

  // Mid-cycle comparison against the model.
  task automatic half();
    @(negedge clock);
    chk("trigger", 32'(trigger), 32'(exp_trig()));
    chk("activate", 32'(activate), 32'(exp_act()));
    chk("all_done", 32'(all_done), 32'(exp_all()));
  endtask

  task automatic edge_();
    @(posedge clock);
    if (reset) m_reset(); else m_step();
    #1;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic set_per(input int i, input int v);
    period[W*i +: W] = W'(v);
  endtask

  task automatic quiet();
    load = '0; clear = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = '0; periodic = '0; clear = '0; period = '0;
    m_reset();
    #2;
    chk("rst_trigger", 32'(trigger), 0);
    chk("rst_activate", 32'(activate), 0);
    chk("rst_all_done", 32'(all_done), 0);
    edge_();
    cyc();
    reset = 1'b0;
    enable = 1'b1;
    cyc();

    // One-shot, period 5: trigger in the 5th cycle after the load edge, then sticky.
    load[0] = 1; set_per(0, 5); periodic[0] = 0;
    cyc();
    quiet();
    for (int k = 1; k <= 8; k++) begin
      half();
      chk("os_trig0", 32'(trigger[0]), 32'(k == 5));
      chk("os_act0", 32'(activate[0]), 32'(k >= 5));
      edge_();
    end

    // Periodic, period 3.
    load[1] = 1; set_per(1, 3); periodic[1] = 1;
    cyc();
    quiet();
    for (int k = 1; k <= 10; k++) begin
      half();
      chk("per_trig1", 32'(trigger[1]), 32'(k % 3 == 0));
      chk("per_act1", 32'(activate[1]), 32'(k % 3 == 0));
      edge_();
    end

    // Period 4, freeze at count 2 for 10 cycles.
    load[2] = 1; set_per(2, 4); periodic[2] = 0;
    cyc();
    quiet();
    cyc(); cyc();
    enable = 0;
    for (int k = 0; k < 10; k++) begin
      half();
      chk("frz_trig2", 32'(trigger[2]), 0);
      edge_();
    end
    enable = 1;
    for (int k = 1; k <= 3; k++) begin
      half();
      chk("resume_trig2", 32'(trigger[2]), 32'(k == 2));
      edge_();
    end

    // Load beats clear; then a zero-period load never fires.
    load[3] = 1; clear[3] = 1; set_per(3, 2); periodic[3] = 0;
    cyc();
    quiet();
    for (int k = 1; k <= 3; k++) begin
      half();
      chk("lc_trig3", 32'(trigger[3]), 32'(k == 2));
      edge_();
    end
    load[3] = 1; set_per(3, 0);
    cyc();
    quiet();
    for (int k = 1; k <= 4; k++) begin
      half();
      chk("zero_act3", 32'(activate[3]), 0);
      edge_();
    end

    // All channels one-shot with periods 1..4.
    load = '1; periodic = '0;
    for (int i = 0; i < N; i++) set_per(i, i + 1);
    cyc();
    quiet();
    for (int k = 1; k <= 6; k++) begin
      half();
      chk("ad_trig3", 32'(trigger[3]), 32'(k == 4));
      chk("ad_all", 32'(all_done), 32'(k >= 5));
      edge_();
    end
    clear[0] = 1;
    cyc();
    quiet();
    half();
    chk("ad_fall", 32'(all_done), 0);
    edge_();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        load[i]     = ($urandom_range(0, 11) == 0);
        clear[i]    = ($urandom_range(0, 15) == 0);
        periodic[i] = $urandom_range(0, 1);
        set_per(i, $urandom_range(0, 6));
      end
      cyc();
    end
    quiet();
    enable = 1;

    // Async reset with every channel done.
    load = '1; periodic = '0;
    for (int i = 0; i < N; i++) set_per(i, 1);
    cyc();
    quiet();
    cyc();
    half();
    chk("pre_rst_all", 32'(all_done), 1);
    #2 reset = 1;
    #1;
    chk("arst_trigger", 32'(trigger), 0);
    chk("arst_activate", 32'(activate), 0);
    chk("arst_all_done", 32'(all_done), 0);
    m_reset();
    edge_();
    reset = 0;
    for (int k = 0; k < 3; k++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
